// File: rtl/seven_segment_reader.sv
// Recovers hex nibbles from a multiplexed active-low 7-segment bus and flags illegal segment patterns.
// Optional feature macro: BLANK_DETECT_EN (all-off pattern clears digit_valid instead of setting pattern_err).
module seven_segment_reader #(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 4,
   parameter int SYNC_STAGES   = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [6:0]              seg_n,
   input  logic [NUM_DIGITS-1:0]   an_n,
   output logic [4*NUM_DIGITS-1:0] hex_out,
   output logic [NUM_DIGITS-1:0]   digit_valid,
   output logic [NUM_DIGITS-1:0]   pattern_err,
   output logic                    upd,
   output logic [2:0]              upd_idx,
   output logic                    frame_done
);

   localparam int SW = NUM_DIGITS + 7;
   localparam int CW = $clog2(STABLE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_FIRE = CW'(STABLE_CYCLES - 2);

   logic [SW-1:0]           sync_q [SYNC_STAGES];
   logic [SW-1:0]           prev_q;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [4*NUM_DIGITS-1:0] hex_q, hex_d;
   logic [NUM_DIGITS-1:0]   valid_q, valid_d;
   logic [NUM_DIGITS-1:0]   err_q, err_d;
   logic [NUM_DIGITS-1:0]   mask_q, mask_d;
   logic                    upd_q, upd_d;
   logic [2:0]              idx_q, idx_d;
   logic                    frame_q, frame_d;

   logic [SW-1:0]           s;
   logic [NUM_DIGITS-1:0]   an_low;
   logic [6:0]              seg_hi;
   logic [4:0]              dec;
   logic                    same, one_low, fire, is_blank;
   logic [NUM_DIGITS-1:0]   mask_nx;
   int                      low_cnt;

   // Returns {legal, nibble} for an active-high gfedcba pattern.
   function automatic logic [4:0] decode(input logic [6:0] seg);
      case (seg)
         7'h3F: decode = 5'h10;
         7'h06: decode = 5'h11;
         7'h5B: decode = 5'h12;
         7'h4F: decode = 5'h13;
         7'h66: decode = 5'h14;
         7'h6D: decode = 5'h15;
         7'h7D: decode = 5'h16;
         7'h07: decode = 5'h17;
         7'h7F: decode = 5'h18;
         7'h67: decode = 5'h19;
         7'h77: decode = 5'h1A;
         7'h7C: decode = 5'h1B;
         7'h39: decode = 5'h1C;
         7'h5E: decode = 5'h1D;
         7'h79: decode = 5'h1E;
         7'h71: decode = 5'h1F;
         default: decode = 5'h00;
      endcase
   endfunction

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      s        = sync_q[SYNC_STAGES-1];
      an_low   = ~s[SW-1:7];
      seg_hi   = ~s[6:0];
      dec      = decode(seg_hi);
      is_blank = (seg_hi == 7'h00);
      same     = (s == prev_q);
      low_cnt  = 0;
      for (int i = 0; i < NUM_DIGITS; i++) low_cnt += int'(an_low[i]);
      one_low  = (low_cnt == 1);

      cnt_d = cnt_q;
      if (!same)                cnt_d = '0;
      else if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      // Fire only on the step into the saturated value, so one commit per stable window.
      fire = same && (cnt_q == CNT_FIRE) && one_low;

      hex_d   = hex_q;
      valid_d = valid_q;
      err_d   = err_q;
      mask_d  = mask_q;
      mask_nx = mask_q;
      idx_d   = idx_q;
      upd_d   = 1'b0;
      frame_d = 1'b0;

      if (fire) begin
         upd_d = 1'b1;
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (an_low[i]) begin
               idx_d      = 3'(i);
               mask_nx[i] = 1'b1;
               if (dec[4]) begin
                  hex_d[4*i +: 4] = dec[3:0];
                  valid_d[i]      = 1'b1;
               end
`ifdef BLANK_DETECT_EN
               else if (is_blank) begin
                  valid_d[i] = 1'b0;
               end
`endif
               else begin
                  err_d[i] = 1'b1;
               end
            end
         end
         if (&mask_nx) begin
            frame_d = 1'b1;
            mask_d  = '0;
         end else begin
            mask_d = mask_nx;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         // NOTE: the sync chain is a handful of flops, so it is reset explicitly to the inactive level.
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '1;
         prev_q  <= '1;
         cnt_q   <= '0;
         hex_q   <= '0;
         valid_q <= '0;
         err_q   <= '0;
         mask_q  <= '0;
         upd_q   <= 1'b0;
         idx_q   <= '0;
         frame_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         sync_q[0] <= {an_n, seg_n};
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         prev_q  <= s;
         cnt_q   <= cnt_d;
         hex_q   <= hex_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         mask_q  <= mask_d;
         upd_q   <= upd_d;
         idx_q   <= idx_d;
         frame_q <= frame_d;
      end
   end

   assign hex_out     = hex_q;
   assign digit_valid = valid_q;
   assign pattern_err = err_q;
   assign upd         = upd_q;
   assign upd_idx     = idx_q;
   assign frame_done  = frame_q;

endmodule

// File: tb/tb_seven_segment_reader.sv
// Directed self-checking bench for seven_segment_reader (NUM_DIGITS=4, STABLE_CYCLES=4, SYNC_STAGES=2).
module tb_seven_segment_reader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [6:0]  seg_n;
   logic [3:0]  an_n;
   logic [15:0] hex_out;
   logic [3:0]  digit_valid;
   logic [3:0]  pattern_err;
   logic        upd;
   logic [2:0]  upd_idx;
   logic        frame_done;

   int checks   = 0;
   int failures = 0;

   int upd_cnt, first_upd, frame_cnt, frame_bad;
   logic [2:0] last_idx;

   seven_segment_reader #(.NUM_DIGITS(4), .STABLE_CYCLES(4), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst_n(rst_n), .seg_n(seg_n), .an_n(an_n),
      .hex_out(hex_out), .digit_valid(digit_valid), .pattern_err(pattern_err),
      .upd(upd), .upd_idx(upd_idx), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Drive inputs just after an edge, then observe n cycles at edge+1.
   task automatic hold(input logic [3:0] an, input logic [6:0] seg, input int n);
      an_n = an; seg_n = seg;
      upd_cnt = 0; first_upd = 0; frame_cnt = 0; frame_bad = 0; last_idx = '0;
      for (int k = 1; k <= n; k++) begin
         @(posedge clk); #1;
         if (upd) begin
            upd_cnt++;
            if (first_upd == 0) first_upd = k;
            last_idx = upd_idx;
         end
         if (frame_done) begin
            frame_cnt++;
            if (!upd) frame_bad++;
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; an_n = 4'hF; seg_n = 7'h7F;
      repeat (3) @(posedge clk);
      #1;
      check("reset_hex", hex_out, 16'h0000);
      check("reset_valid_err_upd", {digit_valid, pattern_err, upd, upd_idx, frame_done}, 0);
      rst_n = 1'b1;

      // Single digit 2 showing 5, with latency.
      hold(4'b1011, 7'h12, 10);
      check("t1_upd_cnt", upd_cnt, 1);
      check("t1_latency", first_upd, 6);
      check("t1_idx", last_idx, 2);
      check("t1_hex", hex_out[11:8], 4'h5);
      check("t1_valid", digit_valid, 4'b0100);
      check("t1_frame", frame_cnt, 0);

      // Full frame 0..3.
      hold(4'b1110, 7'h40, 8);
      check("t2_d0_frame", {upd_cnt, frame_cnt}, {32'd1, 32'd0});
      hold(4'b1101, 7'h79, 8);
      check("t2_d1_frame", {upd_cnt, frame_cnt}, {32'd1, 32'd0});
      hold(4'b1011, 7'h24, 8);
      check("t2_d2_frame", {upd_cnt, frame_cnt}, {32'd1, 32'd0});
      hold(4'b0111, 7'h30, 8);
      check("t2_d3_frame", {upd_cnt, frame_cnt, frame_bad}, {32'd1, 32'd1, 32'd0});
      check("t2_idx", last_idx, 3);
      check("t2_hex", hex_out, 16'h3210);
      check("t2_valid", digit_valid, 4'b1111);

      // Illegal pattern on digit 0.
      hold(4'b1110, 7'h7E, 8);
      check("t3_upd", upd_cnt, 1);
      check("t3_err", pattern_err, 4'b0001);
      check("t3_hex", hex_out, 16'h3210);
      check("t3_valid", digit_valid, 4'b1111);

      // Zero or several enables low: nothing commits.
      hold(4'b1100, 7'h40, 20);
      check("t4_two_low_upd", upd_cnt, 0);
      hold(4'b1111, 7'h12, 20);
      check("t4_none_low_upd", upd_cnt, 0);
      check("t4_state", {hex_out, digit_valid, pattern_err}, {16'h3210, 4'b1111, 4'b0001});

      // Toggling every 3 cycles never commits; then holding commits once.
      begin
         int tog_upd = 0;
         for (int p = 0; p < 6; p++) begin
            hold(4'b1101, (p % 2 == 0) ? 7'h24 : 7'h79, 3);
            tog_upd += upd_cnt;
         end
         check("t5_toggle_upd", tog_upd, 0);
      end
      hold(4'b1101, 7'h24, 10);
      check("t5_hold_upd", upd_cnt, 1);
      check("t5_hex", hex_out, 16'h3220);

      // Reset three cycles into a stable window.
      hold(4'b1011, 7'h40, 3);
      check("t6_pre_reset_upd", upd_cnt, 0);
      rst_n = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      check("t6_reset_outs", {hex_out, digit_valid, pattern_err, upd, frame_done}, 0);
      rst_n = 1'b1;
      hold(4'b1011, 7'h40, 10);
      check("t6_upd_cnt", upd_cnt, 1);
      check("t6_latency", first_upd, 6);
      check("t6_state", {hex_out, digit_valid, pattern_err}, {16'h0000, 4'b0100, 4'b0000});

      // All-off pattern on valid digit 2.
      hold(4'b1011, 7'h7F, 8);
      check("t7_upd", upd_cnt, 1);
`ifdef BLANK_DETECT_EN
      check("t7_blank", {digit_valid, pattern_err}, {4'b0000, 4'b0000});
`else
      check("t7_blank", {digit_valid, pattern_err}, {4'b0100, 4'b0100});
`endif
      check("t7_hex", hex_out, 16'h0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
